// File: rtl/cache_lookup_ctrl.sv
// Lookup and fill controller for a 4-line fully associative cache.
// Read requests are compared against four stored tags. A hit returns the
// cached word; a miss reads the word from memory and fills a victim line.
// Every cycle it drives hit/index into the downstream LRU unit and takes
// that unit's lru_line as the replacement victim once all lines are valid.
// Ports:
//   clk, reset           clock, async active-high reset (shared with LRU unit)
//   req_valid/req_addr   request in; req_ready is high only while idle
//   resp_valid/data/hit  one-cycle response strobe with data and hit flag
//   mem_req/mem_addr     level memory read request, held until mem_valid
//   mem_valid/mem_data   one-cycle memory read return
//   lru_line             LRU unit's least-recently-used line
//   lru_hit/lru_index    LRU touch: 1 = touch lru_index, 0 = touch lru_line
module cache_lookup_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        lru_line,
  output logic              lru_hit,
  output logic [1:0]        lru_index
);

  localparam int unsigned LINES = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [2:0] {IDLE, COMPARE, MISS, FILL, RESP} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [ADDR_W-1:0] tag  [LINES];
  logic [DATA_W-1:0] data [LINES];

  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  victim_q;
  logic              all_valid_q;
  logic [IDX_W-1:0]  last_line;

  logic [LINES-1:0]  match_q, match_req;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_req, free_idx, victim_c, last_line_nx;
  logic              hit_q, hit_req;

  logic              req_ready_nx, resp_valid_nx, resp_hit_nx, mem_req_nx, lru_hit_nx;
  logic [DATA_W-1:0] resp_data_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [IDX_W-1:0]  lru_index_nx;

  // Tag match against the latched address (COMPARE) and the incoming one
  // (so the COMPARE-cycle LRU touch can be registered at the accept edge).
  // Descending scan leaves the lowest matching / lowest invalid index.
  always_comb begin
    match_q     = '0;
    match_req   = '0;
    hit_idx_q   = '0;
    hit_idx_req = '0;
    free_idx    = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      match_q[i]   = valid[i] && (tag[i] == addr_q);
      match_req[i] = valid[i] && (tag[i] == req_addr);
      if (match_q[i])   hit_idx_q   = IDX_W'(i);
      if (match_req[i]) hit_idx_req = IDX_W'(i);
      if (!valid[i])    free_idx    = IDX_W'(i);
    end
  end

  assign hit_q    = |match_q;
  assign hit_req  = |match_req;
  assign victim_c = (&valid) ? lru_line : free_idx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = COMPARE;
      COMPARE: state_nx = hit_q ? RESP : MISS;
      MISS:    if (mem_valid) state_nx = FILL;
      FILL:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Most recently touched line; drives the idempotent LRU re-touch
  always_comb begin
    last_line_nx = last_line;
    if (state == COMPARE && hit_q)       last_line_nx = hit_idx_q;
    else if (state == MISS && mem_valid) last_line_nx = victim_q;
  end

  // Control datapath: address latch, victim choice, valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      addr_q      <= '0;
      victim_q    <= '0;
      all_valid_q <= 1'b0;
      last_line   <= '0;
    end else begin
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == COMPARE && !hit_q) begin
        victim_q    <= victim_c;
        all_valid_q <= &valid;
      end
      last_line <= last_line_nx;
      if (state == MISS && mem_valid) valid[victim_q] <= 1'b1;
    end
  end

  // Tag/data storage; contents are qualified by valid so need no reset
  always_ff @(posedge clk) begin
    if (state == MISS && mem_valid) begin
      tag[victim_q]  <= addr_q;
      data[victim_q] <= mem_data;
    end
  end

  // Output logic: values for the state being entered, registered below
  always_comb begin
    req_ready_nx  = 1'b0;
    resp_valid_nx = 1'b0;
    resp_hit_nx   = resp_hit;
    resp_data_nx  = resp_data;
    mem_req_nx    = 1'b0;
    mem_addr_nx   = mem_addr;
    lru_hit_nx    = 1'b1;
    lru_index_nx  = last_line_nx;
    if (state == COMPARE && hit_q) begin
      resp_hit_nx  = 1'b1;
      resp_data_nx = data[hit_idx_q];
    end else if (state == MISS && mem_valid) begin
      resp_hit_nx  = 1'b0;
      resp_data_nx = mem_data;
    end
    case (state_nx)
      IDLE:    req_ready_nx = 1'b1;
      COMPARE: if (hit_req) lru_index_nx = hit_idx_req;
      MISS: begin
        mem_req_nx  = 1'b1;
        mem_addr_nx = addr_q;
      end
      // With all lines valid the victim is lru_line itself, so touch it
      FILL: begin
        lru_hit_nx   = !all_valid_q;
        lru_index_nx = victim_q;
      end
      RESP:    resp_valid_nx = 1'b1;
      default: req_ready_nx = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      lru_hit    <= 1'b1;
      lru_index  <= '0;
    end else begin
      req_ready  <= req_ready_nx;
      resp_valid <= resp_valid_nx;
      resp_hit   <= resp_hit_nx;
      resp_data  <= resp_data_nx;
      mem_req    <= mem_req_nx;
      mem_addr   <= mem_addr_nx;
      lru_hit    <= lru_hit_nx;
      lru_index  <= lru_index_nx;
    end
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: transaction-level cache model, LRU unit model,
// per-cycle output comparison, plus directed requests with literal expectations.
module tb_cache_lookup_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_hit;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_valid = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic [1:0] lru_line;
  logic       lru_hit;
  logic [1:0] lru_index;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  cache_lookup_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .lru_line(lru_line), .lru_hit(lru_hit), .lru_index(lru_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // LRU unit model: recency list, index 0 = least recently used
  logic [1:0] lru_order [4];
  assign lru_line = lru_order[0];

  always @(posedge clk or posedge reset) begin : lru_model
    logic [1:0] t;
    logic [1:0] nw [4];
    int k;
    if (reset) begin
      for (int i = 0; i < 4; i++) lru_order[i] <= 2'(i);
    end else begin
      t = lru_hit ? lru_index : lru_order[0];
      k = 0;
      for (int i = 0; i < 4; i++) begin
        nw[i] = 2'd0;
      end
      for (int i = 0; i < 4; i++) begin
        if (lru_order[i] != t) begin
          nw[k] = lru_order[i];
          k++;
        end
      end
      nw[3] = t;
      for (int i = 0; i < 4; i++) lru_order[i] <= nw[i];
    end
  end

  // Cache model: where the current request stands, in cycles after accept
  bit         m_busy, m_hit, m_allv;
  int         m_age, m_post;
  logic [7:0] m_addr, m_data;
  logic [1:0] m_line, mru;
  bit         mvalid [4];
  logic [7:0] mtag [4];
  logic [7:0] mdata [4];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      mru    = 2'd0;
      for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_addr = req_addr;
        m_age  = 1;
        m_post = 0;
        m_hit  = 1'b0;
        for (int i = 0; i < 4; i++)
          if (mvalid[i] && mtag[i] == req_addr) begin
            m_hit  = 1'b1;
            m_line = 2'(i);
            m_data = mdata[i];
          end
      end
    end else if (m_hit) begin
      if (m_age == 1) begin
        m_age = 2;
        mru   = m_line;
      end else m_busy = 1'b0;
    end else begin
      if (m_age == 1) begin
        m_age  = 2;
        m_allv = 1'b1;
        m_line = lru_order[0];
        for (int i = 3; i >= 0; i--)
          if (!mvalid[i]) begin
            m_allv = 1'b0;
            m_line = 2'(i);
          end
      end else if (m_post == 0) begin
        if (mem_valid) begin
          mtag[m_line]   = m_addr;
          mdata[m_line]  = mem_data;
          mvalid[m_line] = 1'b1;
          mru            = m_line;
          m_data         = mem_data;
          m_post         = 1;
        end
      end else if (m_post == 1) m_post = 2;
      else m_busy = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  bit         e_ready, e_memreq, e_resp, e_lhit;
  logic [1:0] e_lidx;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      e_ready  = !m_busy;
      e_memreq = m_busy && !m_hit && m_age == 2 && m_post == 0;
      e_resp   = m_busy && ((m_hit && m_age == 2) || (!m_hit && m_post == 2));
      e_lhit   = !(m_busy && !m_hit && m_post == 1 && m_allv);
      if (m_busy && m_hit && m_age == 1)          e_lidx = m_line;
      else if (m_busy && !m_hit && m_post >= 1)   e_lidx = m_line;
      else                                        e_lidx = mru;
      chk("req_ready", req_ready, e_ready);
      chk("mem_req", mem_req, e_memreq);
      chk("resp_valid", resp_valid, e_resp);
      chk("lru_hit", lru_hit, e_lhit);
      chk("lru_index", lru_index, e_lidx);
      if (e_memreq) chk("mem_addr", mem_addr, m_addr);
      if (e_resp) begin
        chk("resp_hit", resp_hit, m_hit);
        chk("resp_data", resp_data, m_data);
      end
    end
  end

  // One request; serves memory after `delay` mem_req cycles, optional noise
  task automatic do_req(input logic [7:0] a, input bit exp_hit, input logic [7:0] exp_data,
                        input int delay, input logic [7:0] md, input logic [1:0] exp_idx,
                        input bit exp_lhit, input bit noise);
    int   cyc, mem_cnt, guard;
    bit   got, addr_ok;
    logic p_lhit;
    logic [1:0] p_idx;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 50);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; mem_cnt = 0; got = 1'b0; addr_ok = 1'b1;
    p_lhit = lru_hit; p_idx = lru_index;
    while (!got && cyc < 100) begin
      mem_valid = 1'b0;
      req_valid = 1'b0;
      if (resp_valid) got = 1'b1;
      else begin
        if (mem_req) begin
          mem_cnt++;
          if (mem_addr !== a) addr_ok = 1'b0;
          if (mem_cnt == delay) begin
            mem_valid = 1'b1;
            mem_data  = md;
          end
          if (noise) begin
            req_valid = 1'b1;
            req_addr  = 8'($urandom);
          end
        end
        p_lhit = lru_hit;
        p_idx  = lru_index;
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 1'b0;
    mem_valid = 1'b0;
    chk("resp_seen", got, 1);
    if (got) begin
      chk("req_resp_hit", resp_hit, exp_hit);
      chk("req_resp_data", resp_data, exp_data);
      chk("req_latency", cyc, exp_hit ? 2 : 3 + delay);
      chk("req_mem_cycles", mem_cnt, exp_hit ? 0 : delay);
      chk("req_mem_addr_stable", addr_ok, 1);
      chk("req_touch_hit", p_lhit, exp_lhit);
      chk("req_touch_index", p_idx, exp_idx);
    end
  endtask

  initial begin
    int guard;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_lru_hit", lru_hit, 1);
    chk("rst_lru_index", lru_index, 0);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Cold misses fill lines 0..3 in order
    do_req(8'h10, 0, 8'hA1, 1, 8'hA1, 2'd0, 1, 0);
    do_req(8'h20, 0, 8'hA2, 1, 8'hA2, 2'd1, 1, 0);
    do_req(8'h30, 0, 8'hA3, 1, 8'hA3, 2'd2, 1, 0);
    do_req(8'h40, 0, 8'hA4, 1, 8'hA4, 2'd3, 1, 0);
    // Hit on line 1
    do_req(8'h20, 1, 8'hA2, 0, 8'h00, 2'd1, 1, 0);
    // All valid: LRU unit picks line 0
    do_req(8'h50, 0, 8'hB5, 1, 8'hB5, 2'd0, 0, 0);
    chk("model_tag0", mtag[0], 8'h50);
    // 0x10 was evicted; LRU is now line 2; slow memory with request noise
    do_req(8'h10, 0, 8'hC1, 7, 8'hC1, 2'd2, 0, 1);
    do_req(8'h50, 1, 8'hB5, 0, 8'h00, 2'd0, 1, 0);

    // Reset while waiting on memory
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 50);
    req_valid = 1'b1;
    req_addr  = 8'h60;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("miss_reached", mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_hit", resp_hit, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_lru_hit", lru_hit, 1);
    chk("mid_rst_lru_index", lru_index, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_data  = 8'hEE;
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    // Valid bits cleared: 0x20 misses into line 0
    do_req(8'h20, 0, 8'hD2, 1, 8'hD2, 2'd0, 1, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
